// File: rtl/imm_encoder.sv
// Searches the 16 ARM rotations for a 32-bit constant's {rot, imm8} encoding.
// Result appears k+1 cycles after accept (16 if not encodable) and is held until out_ready.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        encodable,
  output logic [11:0] shift_operand,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [3:0]  k_q, k_d;
  logic        enc_q, enc_d;
  logic [11:0] so_q, so_d;

  logic [4:0]  shamt;
  logic [31:0] cand;

  // Rotating left by 2k undoes the ROR applied by the decoder.
  assign shamt = {k_q, 1'b0};
  assign cand  = (value_q << shamt) | (value_q >> (6'd32 - {1'b0, shamt}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      value_q <= 32'h0;
      k_q     <= 4'h0;
      enc_q   <= 1'b0;
      so_q    <= 12'h000;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      k_q     <= k_d;
      enc_q   <= enc_d;
      so_q    <= so_d;
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    k_d     = k_q;
    enc_d   = enc_q;
    so_d    = so_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          value_d = value;
          k_d     = 4'h0;
          enc_d   = 1'b0;
          so_d    = 12'h000;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (cand[31:8] == 24'h0) begin
          enc_d   = 1'b1;
          so_d    = {k_q, cand[7:0]};
          state_d = DONE;
        end else if (k_q == 4'hF) begin
          enc_d   = 1'b0;
          so_d    = 12'h000;
          state_d = DONE;
        end else begin
          k_d = k_q + 4'h1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign encodable     = enc_q;
  assign shift_operand = so_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder against a brute-force decode-side model.
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic        out_valid;
  logic        out_ready;
  logic        encodable;
  logic [11:0] shift_operand;
  logic        busy;

  int checks;
  int failures;

  imm_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .value         (value),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .encodable     (encodable),
    .shift_operand (shift_operand),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    logic [63:0] d;
    d = {x, x} >> s;
    return d[31:0];
  endfunction

  // Enumerates every (rot, imm8) pair in decode order; first hit is the smallest rot.
  task automatic model(input logic [31:0] v, output logic enc, output logic [11:0] so,
                       output int lat);
    bit found;
    found = 1'b0;
    enc   = 1'b0;
    so    = 12'h000;
    lat   = 16;
    for (int r = 0; r < 16 && !found; r++) begin
      for (int imm = 0; imm < 256 && !found; imm++) begin
        if (ror32(imm, 2 * r) == v) begin
          logic [3:0] rr;
          logic [7:0] ii;
          rr    = r[3:0];
          ii    = imm[7:0];
          found = 1'b1;
          enc   = 1'b1;
          so    = {rr, ii};
          lat   = r + 1;
        end
      end
    end
  endtask

  task automatic run_req(input logic [31:0] v, input bit noisy, input int hold);
    logic        exp_enc;
    logic [11:0] exp_so;
    int          exp_lat;
    int          lat;
    model(v, exp_enc, exp_so, exp_lat);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    value    = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    value    = $urandom;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      if (noisy) begin
        in_valid = $urandom_range(0, 1);
        value    = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check($sformatf("latency_%h", v), lat, exp_lat);
    check($sformatf("out_valid_%h", v), out_valid, 1);
    check($sformatf("encodable_%h", v), encodable, exp_enc);
    check($sformatf("shift_operand_%h", v), shift_operand, exp_so);
    check("in_ready_in_done", in_ready, 0);
    check("busy_in_done", busy, 1);
    if (encodable === 1'b1)
      check($sformatf("round_trip_%h", v), ror32(shift_operand[7:0], 2 * shift_operand[11:8]), v);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_shift_operand", shift_operand, exp_so);
      check("hold_encodable", encodable, exp_enc);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    value     = $urandom;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_busy", busy, 0);
  endtask

  initial begin
    logic [31:0] v;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    value     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_encodable", encodable, 0);
    check("reset_shift_operand", shift_operand, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_req(32'h000000FF, 1'b0, 0);
    run_req(32'hFF000000, 1'b0, 0);
    run_req(32'hC000003F, 1'b0, 0);
    run_req(32'h000003FC, 1'b0, 0);
    run_req(32'h00000000, 1'b0, 0);
    run_req(32'h00000101, 1'b0, 0);
    run_req(32'hFF000000, 1'b1, 10);
    run_req(32'h00000101, 1'b1, 3);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0:       v = ror32($urandom_range(0, 255), 2 * $urandom_range(0, 15));
        1:       v = $urandom;
        default: v = ror32($urandom_range(0, 511), $urandom_range(0, 31));
      endcase
      run_req(v, n[0], $urandom_range(0, 2));
    end

    // Abort a search with an asynchronous reset while k=7.
    in_valid = 1'b1;
    value    = 32'h00000101;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_encodable", encodable, 0);
    check("abort_shift_operand", shift_operand, 0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_result", out_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("post_abort_idle", out_valid, 0);
    end
    run_req(32'h000000FF, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the Val2 immediate decode for data-processing operands.
- Takes a 32-bit constant and searches iteratively for the ARM rotated-immediate encoding: 12-bit shift_operand = {rot[3:0], imm8[7:0]}, where value = ROR32(imm8, 2*rot).
- Used by the instruction-injection/debug path to build data-processing immediates in hardware.
- Tests one rotation per cycle and returns the smallest matching rot, or flags the value as not encodable.

Parameters:
- None. The rotation count is architecturally fixed at 16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request; high only in IDLE
- value  input  32  constant to encode; sampled on accept
- out_valid  output  1  result valid; held until out_ready
- out_ready  input  1  consumer accepts result
- encodable  output  1  1 = a valid encoding was found
- shift_operand  output  12  {rot, imm8}; 12'h000 when encodable=0
- busy  output  1  high in SEARCH or DONE

Behaviour:
- One clock domain. Reset is asynchronous and active-low; all flops clear immediately when rst_n=0.
- Reset values: state=IDLE, in_ready=1, out_valid=0, encodable=0, shift_operand=12'h000, busy=0, internal value register=0, rot counter=0.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: latch value, set rot counter k=0, go to SEARCH.
- SEARCH (cycle after E0+k):
  - cand = ROL32(value_reg, 2*k), a pure combinational rotate-left by 2k.
  - If cand[31:8]==0: at the next edge, register encodable=1 and shift_operand={k[3:0], cand[7:0]}, assert out_valid, go to DONE.
  - Else if k==15: at the next edge, register encodable=0, shift_operand=0, assert out_valid, go to DONE.
  - Else: k <= k+1.
  - The first match wins, so the smallest rot is always reported.
- Latency:
  - A match at rot k gives out_valid high k+1 cycles after the accept edge. Minimum is 1, maximum is 16.
  - No match gives out_valid high 16 cycles after the accept edge.
- DONE:
  - out_valid=1; encodable and shift_operand are held stable.
  - On out_valid&&out_ready: clear out_valid, go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
  - out_ready is ignored outside DONE.
- in_valid is ignored unless in IDLE. The value input is only sampled at accept.
- Boundary cases:
  - value=0 encodes as rot=0, imm8=0.
  - k wraps only under reset; it never increments past 15.
  - Reset asserted mid-SEARCH or mid-DONE aborts the operation: no result is emitted, and the block returns to IDLE with reset values.
- Round trip: when encodable=1, decoding shift_operand through the Val2 immediate path (immd=1, is_mem_command=0) must reproduce value exactly.

Test Plan:
- Minimum latency: accept value=32'h000000FF → out_valid exactly 1 cycle after accept; encodable=1, shift_operand=12'h0FF.
- Mid-range rotation: accept 32'hFF000000 → out_valid 5 cycles after accept; shift_operand=12'h4FF (rot=4). Then accept 32'hC000003F → shift_operand=12'h1FF after 2 cycles.
- Last-rotation match: accept 32'h000003FC → match found at k=15; out_valid 16 cycles after accept; shift_operand=12'hFFF... must equal {4'hF, 8'hFF}. Also accept 32'h0 → shift_operand=12'h000, encodable=1, latency 1.
- Not encodable: accept 32'h00000101 → out_valid 16 cycles after accept; encodable=0, shift_operand=12'h000.
- Backpressure and idle inputs:
  - Hold out_ready=0 for 10 cycles in DONE → outputs stay stable, in_ready stays 0.
  - Toggle in_valid with new values during SEARCH → ignored, result unaffected.
  - Raise out_ready → IDLE, in_ready=1 on the next cycle.
- Reset mid-operation: drop rst_n asynchronously (between edges) at k=7 during SEARCH for 32'h00000101 → outputs reset immediately, no out_valid. After release, a new request for 32'h000000FF completes normally with latency 1.
